pipeline_trace_tagger: RTL

//  Synthesizable producer of per-instruction retire trace records for the 5-stage

---
 rtl/pipeline_trace_tagger.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipeline_trace_tagger.sv
// Shadows each fetched instruction through the 5-stage pipeline with a sequence tag.
// Every retiring instruction leaves one record in a show-ahead FIFO read by valid/ready.
module pipeline_trace_tagger #(
  parameter int TAG_MAX    = 72,
  parameter int TAG_W      = 7,
  parameter int PC_W       = 16,
  parameter int CYC_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic             pc_stall,
  input  logic             if_id_stall,
  input  logic             if_flush,
  input  logic             id_flush,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [TAG_W-1:0] trace_tag,
  output logic [PC_W-1:0]  trace_pc,
  output logic [CYC_W-1:0] trace_fetch_cycle,
  output logic [CYC_W-1:0] trace_wb_cycle,
  output logic             overflow,
  output logic [CYC_W-1:0] cycle
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NSTG  = 4;  // IF/ID, ID/EX, EX/MEM, MEM/WB

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  pc;
    logic [CYC_W-1:0] fcyc;
  } stage_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  pc;
    logic [CYC_W-1:0] fcyc;
    logic [CYC_W-1:0] wcyc;
  } rec_t;

  stage_t           stg_reg [NSTG];
  rec_t             fifo_mem [FIFO_DEPTH];
  rec_t             head;
  logic [CYC_W-1:0] cycle_reg;
  logic [TAG_W-1:0] next_tag_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;

  logic accept;
  logic push;
  logic pop;
  logic full;
  logic wr_en;

  assign accept = fetch_valid & ~pc_stall & ~if_id_stall & ~if_flush;
  assign push   = stg_reg[NSTG-1].valid;
  assign pop    = trace_valid & trace_ready;
  assign full   = (count_reg == CNT_W'(FIFO_DEPTH));
  // A full FIFO still takes the record when the head leaves in the same cycle.
  assign wr_en  = push & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_reg    <= '0;
      next_tag_reg <= '0;
      for (int i = 0; i < NSTG; i++) stg_reg[i] <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      cycle_reg <= cycle_reg + 1'b1;

      if (accept) begin
        next_tag_reg <= (next_tag_reg == TAG_W'(TAG_MAX - 1)) ? '0 : next_tag_reg + 1'b1;
      end

      if (if_flush) begin
        stg_reg[0].valid <= 1'b0;
      end else if (!if_id_stall) begin
        stg_reg[0].valid <= accept;
        if (accept) begin
          stg_reg[0].tag  <= next_tag_reg;
          stg_reg[0].pc   <= fetch_pc;
          stg_reg[0].fcyc <= cycle_reg;
        end
      end

      // A decode stall leaves a bubble behind the held IF/ID entry.
      if (id_flush || if_id_stall) begin
        stg_reg[1].valid <= 1'b0;
      end else begin
        stg_reg[1] <= stg_reg[0];
      end

      for (int i = 2; i < NSTG; i++) stg_reg[i] <= stg_reg[i-1];

      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(wr_en) - CNT_W'(pop);
      if (push && full && !pop) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_reg] <= {stg_reg[NSTG-1].tag, stg_reg[NSTG-1].pc,
                               stg_reg[NSTG-1].fcyc, cycle_reg};
    end
  end

  // Head fields are forced to zero while empty so stale storage never shows.
  assign head              = fifo_mem[rd_ptr_reg];
  assign trace_valid       = (count_reg != '0);
  assign trace_tag         = trace_valid ? head.tag  : '0;
  assign trace_pc          = trace_valid ? head.pc   : '0;
  assign trace_fetch_cycle = trace_valid ? head.fcyc : '0;
  assign trace_wb_cycle    = trace_valid ? head.wcyc : '0;
  assign overflow          = overflow_reg;
  assign cycle             = cycle_reg;

endmodule
